// File: rtl/vga_pkg.sv
// vga_pkg: shared coordinate type and default 640x480@60 Hz raster timing.
package vga_pkg;

  typedef logic [9:0] coord_t;

  // Horizontal timing, in pixels
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  // Vertical timing, in lines
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Inclusive sync windows (active-low pulse while count is inside)
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis. Counts 0..TOTAL-1 on en, flags the wrap
// combinationally, and registers sync_n/visible from the next count so they
// move on the same edge as count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 751,
  parameter int VISIBLE    = 640
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       en,
  output logic [9:0] count,
  output logic       wrap,
  output logic       sync_n,
  output logic       visible
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);
  localparam coord_t SS   = coord_t'(SYNC_START);
  localparam coord_t SE   = coord_t'(SYNC_END);
  localparam coord_t VIS  = coord_t'(VISIBLE);

  coord_t count_q, count_d;
  logic   sync_n_q, visible_q;

  assign wrap = en && (count_q == LAST);

  // Next count: hold, increment, or wrap to zero
  always_comb begin
    count_d = count_q;
    if (en) count_d = (count_q == LAST) ? '0 : count_q + 10'd1;
  end

  // Count plus decoded sync/visible, all taken from the next-state value
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q   <= '0;
      sync_n_q  <= 1'b1;
      visible_q <= 1'b1;
    end else begin
      count_q   <= count_d;
      sync_n_q  <= !((count_d >= SS) && (count_d <= SE));
      visible_q <= (count_d < VIS);
    end
  end

  assign count   = count_q;
  assign sync_n  = sync_n_q;
  assign visible = visible_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing on the system clock with a pixel-rate
// clock enable. Optional macro VGA_RGB_PIPE_EN delays hs/vs/blank by one
// pixel to match a registered colour path; coordinates and frame_tick are
// unaffected.
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       pixel_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output logic       frame_tick
);
  import vga_pkg::*;

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // CLK_DIV == 1 still needs a 1-bit divider register; it just stays at 0
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pixel_en_q;

  // Divider next state
  always_comb div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

  // Divider and registered pixel strobe, high while div_q sits at its last value
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q      <= '0;
      pixel_en_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      pixel_en_q <= (div_d == DIV_LAST);
    end
  end

  coord_t h_cnt, v_cnt;
  logic   h_wrap, h_sync_n, h_vis;
  logic   v_wrap_unused, v_sync_n, v_vis;

  vga_axis_counter #(
    .TOTAL      (H_TOT),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC - 1),
    .VISIBLE    (H_VISIBLE)
  ) u_h (
    .Clk     (Clk),
    .Reset   (Reset),
    .en      (pixel_en_q),
    .count   (h_cnt),
    .wrap    (h_wrap),
    .sync_n  (h_sync_n),
    .visible (h_vis)
  );

  // Vertical axis steps only on the end-of-line pixel
  vga_axis_counter #(
    .TOTAL      (V_TOT),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC - 1),
    .VISIBLE    (V_VISIBLE)
  ) u_v (
    .Clk     (Clk),
    .Reset   (Reset),
    .en      (h_wrap),
    .count   (v_cnt),
    .wrap    (v_wrap_unused),
    .sync_n  (v_sync_n),
    .visible (v_vis)
  );

  logic frame_tick_q, frame_tick_d;

  // Tick on the edge that moves the raster from the last visible line into blanking
  always_comb frame_tick_d = h_wrap && (v_cnt == coord_t'(V_VISIBLE - 1));

  // Registered frame tick
  always_ff @(posedge Clk) begin
    if (Reset) frame_tick_q <= 1'b0;
    else       frame_tick_q <= frame_tick_d;
  end

`ifdef VGA_RGB_PIPE_EN
  logic hs_q, vs_q, blank_q;

  // One-pixel delay so sync/blank line up with a colour value read one pixel late
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
    end else if (pixel_en_q) begin
      hs_q    <= h_sync_n;
      vs_q    <= v_sync_n;
      blank_q <= h_vis & v_vis;
    end
  end

  assign hs    = hs_q;
  assign vs    = vs_q;
  assign blank = blank_q;
`else
  assign hs    = h_sync_n;
  assign vs    = v_sync_n;
  assign blank = h_vis & v_vis;
`endif

  assign pixel_en   = pixel_en_q;
  assign DrawX      = h_cnt;
  assign DrawY      = v_cnt;
  assign sync       = 1'b0;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checkpoints queued by the stimulus, popped and
// compared by a negedge monitor that also measures sync pulse widths and
// frame_tick spacing. The vertical timing is shortened (20 lines per frame)
// so several frames fit in a short run; horizontal timing is the default.
module tb_vga_timing_gen;

  localparam int CLK_DIV = 2;
  localparam int V_VIS   = 12;
  localparam int V_FP    = 3;
  localparam int V_SY    = 2;
  localparam int V_BP    = 3;
  localparam int V_TOT   = V_VIS + V_FP + V_SY + V_BP;

  localparam int HS_LOW  = vga_pkg::H_SYNC * CLK_DIV;         // 192
  localparam int VS_LOW  = V_SY * vga_pkg::H_TOTAL * CLK_DIV; // 3200
  localparam int FRAME   = vga_pkg::H_TOTAL * V_TOT * CLK_DIV; // 32000

`ifdef VGA_RGB_PIPE_EN
  localparam int PD = CLK_DIV;
`else
  localparam int PD = 0;
`endif

  localparam int S_X = 0, S_Y = 1, S_HS = 2, S_VS = 3, S_BL = 4, S_PE = 5, S_FT = 6, S_SY = 7;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       pixel_en, hs, vs, blank, sync, frame_tick;
  logic [9:0] DrawX, DrawY;

  vga_timing_gen #(
    .CLK_DIV   (CLK_DIV),
    .V_VISIBLE (V_VIS),
    .V_FRONT   (V_FP),
    .V_SYNC    (V_SY),
    .V_BACK    (V_BP)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .pixel_en   (pixel_en),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .hs         (hs),
    .vs         (vs),
    .blank      (blank),
    .sync       (sync),
    .frame_tick (frame_tick)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int    cyc;
    int    sel;
    int    val;
    string name;
  } chk_t;

  chk_t q[$];
  int   n = 0;
  int   errors = 0;
  int   checks = 0;
  logic finish_req = 1'b0;

  always @(posedge Clk) n <= n + 1;

  // Insert keeping the queue ordered by absolute cycle
  function automatic void push(int base, int c, int sel, int val, string name);
    chk_t e;
    int   i = 0;
    e.cyc = base + c; e.sel = sel; e.val = val; e.name = name;
    while (i < q.size() && q[i].cyc <= e.cyc) i++;
    q.insert(i, e);
  endfunction

  function automatic int sample(int sel);
    case (sel)
      S_X:     return int'(DrawX);
      S_Y:     return int'(DrawY);
      S_HS:    return int'(hs);
      S_VS:    return int'(vs);
      S_BL:    return int'(blank);
      S_PE:    return int'(pixel_en);
      S_FT:    return int'(frame_tick);
      default: return int'(sync);
    endcase
  endfunction

  function automatic void push_reset_state(int b);
    push(b, 0, S_X,  0, "rst_x");
    push(b, 0, S_Y,  0, "rst_y");
    push(b, 0, S_HS, 1, "rst_hs");
    push(b, 0, S_VS, 1, "rst_vs");
    push(b, 0, S_BL, 1, "rst_blank");
    push(b, 0, S_PE, 0, "rst_pe");
    push(b, 0, S_FT, 0, "rst_ft");
    push(b, 1, S_PE, 1, "first_pe");
    push(b, 2, S_X,  1, "x_at_2");
    push(b, 2, S_PE, 0, "pe_low_2");
    push(b, 4, S_X,  2, "x_at_4");
  endfunction

  task automatic wait_until(int t);
    while (n < t) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Stimulus: reset, queue expectations, mid-frame reset, queue again
  initial begin
    int b1, b2;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    b1 = n;
    push_reset_state(b1);
    push(b1, 0,         S_SY, 0,   "sync_const");
    push(b1, 1,         S_X,  0,   "x_hold_1");
    push(b1, 1279,      S_X,  639, "x_639");
    push(b1, 1279 + PD, S_BL, 1,   "blank_before_640");
    push(b1, 1280,      S_X,  640, "x_640");
    push(b1, 1280 + PD, S_BL, 0,   "blank_fall");
    push(b1, 1311 + PD, S_HS, 1,   "hs_before_fall");
    push(b1, 1312,      S_X,  656, "x_656");
    push(b1, 1312 + PD, S_HS, 0,   "hs_fall");
    push(b1, 1503 + PD, S_HS, 0,   "hs_before_rise");
    push(b1, 1504,      S_X,  752, "x_752");
    push(b1, 1504 + PD, S_HS, 1,   "hs_rise");
    push(b1, 17599,     S_X,  799, "eol_x");
    push(b1, 17599,     S_Y,  10,  "eol_y");
    push(b1, 17599,     S_PE, 1,   "eol_pe");
    push(b1, 17600,     S_X,  0,   "wrap_x");
    push(b1, 17600,     S_Y,  11,  "wrap_y");
    push(b1, 19199,     S_FT, 0,   "ft_before");
    push(b1, 19200,     S_FT, 1,   "ft_pulse");
    push(b1, 19200,     S_Y,  12,  "ft_y");
    push(b1, 19200,     S_X,  0,   "ft_x");
    push(b1, 19200 + PD, S_BL, 0,  "vblank");
    push(b1, 19201,     S_FT, 0,   "ft_after");
    push(b1, 23999 + PD, S_VS, 1,  "vs_before_fall");
    push(b1, 24000,     S_Y,  15,  "y_15");
    push(b1, 24000 + PD, S_VS, 0,  "vs_fall");
    push(b1, 27199 + PD, S_VS, 0,  "vs_before_rise");
    push(b1, 27200,     S_Y,  17,  "y_17");
    push(b1, 27200 + PD, S_VS, 1,  "vs_rise");
    push(b1, 31999,     S_Y,  19,  "last_line_y");
    push(b1, 31999,     S_X,  799, "last_line_x");
    push(b1, 31999 + PD, S_BL, 0,  "blank_last");
    push(b1, 32000,     S_Y,  0,   "frame_wrap_y");
    push(b1, 32000,     S_X,  0,   "frame_wrap_x");
    push(b1, 32000 + PD, S_BL, 1,  "blank_return");
    push(b1, 51199,     S_FT, 0,   "ft2_before");
    push(b1, 51200,     S_FT, 1,   "ft2_pulse");
    push(b1, 51201,     S_FT, 0,   "ft2_after");
    push(b1, 72600,     S_X,  300, "pre_rst_x");
    push(b1, 72600,     S_Y,  5,   "pre_rst_y");
    push(b1, 72600,     S_HS, 1,   "pre_rst_hs");
    Reset = 1'b0;

    wait_until(b1 + 72600);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    b2 = n;
    push_reset_state(b2);
    push(b2, 1280 + PD, S_BL, 0,   "r2_blank_fall");
    push(b2, 1312,      S_X,  656, "r2_x_656");
    push(b2, 1312 + PD, S_HS, 0,   "r2_hs_fall");
    Reset = 1'b0;

    wait_until(b2 + 1400);
    finish_req = 1'b1;
  end

  // Monitor: pop due checkpoints, measure pulse widths and tick spacing
  always @(negedge Clk) begin : mon
    chk_t e;
    int   got;
    int   hs_run, vs_run, last_tick, ticks;
    logic prev_ft;
    if (n == 0) begin
      hs_run = 0; vs_run = 0; last_tick = -1; ticks = 0; prev_ft = 1'b0;
    end
    if (Reset) begin
      hs_run = 0; vs_run = 0; last_tick = -1; prev_ft = 1'b0;
    end else begin
      if (!hs) hs_run++;
      else if (hs_run != 0) begin
        checks++;
        if (hs_run != HS_LOW) begin
          errors++;
          $display("FAIL hs_low_width: got %0d cycles, expected %0d", hs_run, HS_LOW);
        end
        hs_run = 0;
      end
      if (!vs) vs_run++;
      else if (vs_run != 0) begin
        checks++;
        if (vs_run != VS_LOW) begin
          errors++;
          $display("FAIL vs_low_width: got %0d cycles, expected %0d", vs_run, VS_LOW);
        end
        vs_run = 0;
      end
      if (frame_tick) begin
        checks++;
        if (prev_ft) begin
          errors++;
          $display("FAIL ft_width: frame_tick high on consecutive cycles at %0d, expected 1-cycle pulse", n);
        end else begin
          ticks++;
          if (last_tick >= 0) begin
            checks++;
            if (n - last_tick != FRAME) begin
              errors++;
              $display("FAIL ft_period: got %0d cycles, expected %0d", n - last_tick, FRAME);
            end
          end
          last_tick = n;
        end
      end
      prev_ft = frame_tick;
    end

    while (q.size() > 0 && q[0].cyc <= n) begin
      e = q.pop_front();
      checks++;
      got = sample(e.sel);
      if (e.cyc < n) begin
        errors++;
        $display("FAIL %s: checkpoint cycle %0d missed (now %0d)", e.name, e.cyc, n);
      end else if (got != e.val) begin
        errors++;
        $display("FAIL %s @%0d: got %0d, expected %0d", e.name, e.cyc, got, e.val);
      end
    end

    if (finish_req) begin
      checks++;
      if (ticks != 2) begin
        errors++;
        $display("FAIL ft_count: got %0d pulses, expected 2", ticks);
      end
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL leftover: got %0d unchecked checkpoints, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

endmodule
